// File: rtl/class_router_fifo.sv
// rtl/class_router_fifo.sv - class router: steers each word by its top class bits into one of 2**CLASS_BITS FIFOs
// Each channel has its own pop, registered read port, status flags and sticky error flag.
module class_router_fifo #(
  parameter int DATA_SIZE   = 10,
  parameter int CLASS_BITS  = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALMOST_FULL = 3,
  localparam int NCH        = 2**CLASS_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_SIZE-1:0]     in,
  input  logic                     valid,
  input  logic [NCH-1:0]           pop,
  output logic [NCH*DATA_SIZE-1:0] out,
  output logic [NCH-1:0]           fifo_empty,
  output logic [NCH-1:0]           fifo_full,
  output logic [NCH-1:0]           almost_full,
  output logic                     Error,
  output logic [NCH-1:0]           err_status
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_SIZE-1:0]          mem_q [NCH][FIFO_DEPTH];
  logic [DATA_SIZE-1:0]          mem_d [NCH][FIFO_DEPTH];
  logic [NCH-1:0][PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [NCH-1:0][PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [NCH-1:0][CW-1:0]        count_q, count_d;
  logic [NCH-1:0][DATA_SIZE-1:0] out_q, out_d;
  logic                          error_q, error_d;
  logic [NCH-1:0]                err_status_q, err_status_d;

  logic [CLASS_BITS-1:0] cls;
  logic [NCH-1:0]        ch_empty, ch_full, push_en, pop_en;

  assign cls = in[DATA_SIZE-1 -: CLASS_BITS];

  always_comb begin
    ch_empty    = '0;
    ch_full     = '0;
    almost_full = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_empty[k]    = (count_q[k] == '0);
      ch_full[k]     = (count_q[k] == CW'(FIFO_DEPTH));
      almost_full[k] = (count_q[k] >= CW'(ALMOST_FULL));
    end
  end

  assign fifo_empty = ch_empty;
  assign fifo_full  = ch_full;
  assign out        = out_q;
  assign Error      = error_q;
  assign err_status = err_status_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_d        = out_q;
    err_status_d = err_status_q;
    error_d      = 1'b0;
    push_en      = '0;
    pop_en       = '0;
    for (int k = 0; k < NCH; k++) begin
      pop_en[k] = pop[k] && !ch_empty[k];
      // A full channel still accepts a push when it is popped in the same cycle.
      push_en[k] = valid && (cls == CLASS_BITS'(k)) && (!ch_full[k] || pop[k]);
      if (push_en[k]) begin
        mem_d[k][wr_ptr_q[k]] = in;
        wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
      end
      if (pop_en[k]) begin
        out_d[k]    = mem_q[k][rd_ptr_q[k]];
        rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
      end
      case ({push_en[k], pop_en[k]})
        2'b10:   count_d[k] = count_q[k] + CW'(1);
        2'b01:   count_d[k] = count_q[k] - CW'(1);
        default: count_d[k] = count_q[k];
      endcase
      if ((valid && (cls == CLASS_BITS'(k)) && ch_full[k] && !pop[k]) ||
          (pop[k] && ch_empty[k])) begin
        err_status_d[k] = 1'b1;
        error_d         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[k][j] <= '0;
        end
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_q        <= '0;
      error_q      <= 1'b0;
      err_status_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_q        <= out_d;
      error_q      <= error_d;
      err_status_q <= err_status_d;
    end
  end
endmodule

// File: tb/tb_class_router_fifo.sv
// tb/tb_class_router_fifo.sv - self-checking bench for class_router_fifo (2 channels, depth 4)
module tb_class_router_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [9:0]  in_w = '0;
  logic [1:0]  pop = '0;
  logic [19:0] out;
  logic [1:0]  fifo_empty, fifo_full, almost_full, err_status;
  logic        Error;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  class_router_fifo #(
    .DATA_SIZE(10), .CLASS_BITS(1), .FIFO_DEPTH(4), .ALMOST_FULL(3)
  ) dut (
    .clk(clk), .reset(reset), .in(in_w), .valid(valid), .pop(pop), .out(out),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_full(almost_full),
    .Error(Error), .err_status(err_status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per channel, results go through a scoreboard queue.
  logic [9:0] mq0[$];
  logic [9:0] mq1[$];
  logic [9:0] m_o0 = '0;
  logic [9:0] m_o1 = '0;
  logic [1:0] m_es = '0;

  typedef struct packed {
    logic [9:0] o0;
    logic [9:0] o1;
    logic       er;
    logic [1:0] es;
    logic [1:0] em;
    logic [1:0] fu;
    logic [1:0] af;
  } sb_t;
  sb_t sb_q[$];

  task automatic step(input logic v, input logic [9:0] d, input logic [1:0] p);
    sb_t e;
    bit  f0, f1;
    logic er;
    f0 = (mq0.size() == 4);
    f1 = (mq1.size() == 4);
    er = 1'b0;
    valid = v; in_w = d; pop = p;
    if (p[0]) begin
      if (mq0.size() == 0) begin er = 1'b1; m_es[0] = 1'b1; end
      else m_o0 = mq0.pop_front();
    end
    if (p[1]) begin
      if (mq1.size() == 0) begin er = 1'b1; m_es[1] = 1'b1; end
      else m_o1 = mq1.pop_front();
    end
    if (v) begin
      if (!d[9]) begin
        if (!f0 || p[0]) mq0.push_back(d);
        else begin er = 1'b1; m_es[0] = 1'b1; end
      end else begin
        if (!f1 || p[1]) mq1.push_back(d);
        else begin er = 1'b1; m_es[1] = 1'b1; end
      end
    end
    e.o0 = m_o0; e.o1 = m_o1; e.er = er; e.es = m_es;
    e.em = {mq1.size() == 0, mq0.size() == 0};
    e.fu = {mq1.size() == 4, mq0.size() == 4};
    e.af = {mq1.size() >= 3, mq0.size() >= 3};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0; pop = '0;
    e = sb_q.pop_front();
    check("sb_out0", 32'(out[9:0]), 32'(e.o0));
    check("sb_out1", 32'(out[19:10]), 32'(e.o1));
    check("sb_error", 32'(Error), 32'(e.er));
    check("sb_err_status", 32'(err_status), 32'(e.es));
    check("sb_flags", {26'd0, fifo_empty, fifo_full, almost_full}, {26'd0, e.em, e.fu, e.af});
  endtask

  typedef struct {
    logic       v;
    logic [9:0] d;
    logic [1:0] p;
    logic [9:0] o0;
    logic [9:0] o1;
    logic [1:0] em;
    logic [1:0] fu;
    logic [1:0] af;
    logic       er;
    logic [1:0] es;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [9:0] d, logic [1:0] p, logic [9:0] o0, logic [9:0] o1,
                              logic [1:0] em, logic [1:0] fu, logic [1:0] af, logic er, logic [1:0] es);
    vec_t r;
    r.v = v; r.d = d; r.p = p; r.o0 = o0; r.o1 = o1;
    r.em = em; r.fu = fu; r.af = af; r.er = er; r.es = es;
    return r;
  endfunction

  initial begin
    // routing
    tbl.push_back(mk(1, 10'h0FF, 2'b00, 10'h000, 10'h000, 2'b10, 2'b00, 2'b00, 0, 2'b00));
    tbl.push_back(mk(1, 10'h2DD, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00, 2'b00, 0, 2'b00));
    tbl.push_back(mk(1, 10'h0EE, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00, 2'b00, 0, 2'b00));
    tbl.push_back(mk(1, 10'h2CC, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00, 2'b00, 0, 2'b00));
    tbl.push_back(mk(0, 10'h000, 2'b11, 10'h0FF, 10'h2DD, 2'b00, 2'b00, 2'b00, 0, 2'b00));
    tbl.push_back(mk(0, 10'h000, 2'b11, 10'h0EE, 10'h2CC, 2'b11, 2'b00, 2'b00, 0, 2'b00));
    // overflow on channel 0
    tbl.push_back(mk(1, 10'h011, 2'b00, 10'h0EE, 10'h2CC, 2'b10, 2'b00, 2'b00, 0, 2'b00));
    tbl.push_back(mk(1, 10'h012, 2'b00, 10'h0EE, 10'h2CC, 2'b10, 2'b00, 2'b00, 0, 2'b00));
    tbl.push_back(mk(1, 10'h013, 2'b00, 10'h0EE, 10'h2CC, 2'b10, 2'b00, 2'b01, 0, 2'b00));
    tbl.push_back(mk(1, 10'h014, 2'b00, 10'h0EE, 10'h2CC, 2'b10, 2'b01, 2'b01, 0, 2'b00));
    tbl.push_back(mk(1, 10'h015, 2'b00, 10'h0EE, 10'h2CC, 2'b10, 2'b01, 2'b01, 1, 2'b01));
    tbl.push_back(mk(0, 10'h000, 2'b00, 10'h0EE, 10'h2CC, 2'b10, 2'b01, 2'b01, 0, 2'b01));
    tbl.push_back(mk(0, 10'h000, 2'b01, 10'h011, 10'h2CC, 2'b10, 2'b00, 2'b01, 0, 2'b01));
    tbl.push_back(mk(0, 10'h000, 2'b01, 10'h012, 10'h2CC, 2'b10, 2'b00, 2'b00, 0, 2'b01));
    tbl.push_back(mk(0, 10'h000, 2'b01, 10'h013, 10'h2CC, 2'b10, 2'b00, 2'b00, 0, 2'b01));
    tbl.push_back(mk(0, 10'h000, 2'b01, 10'h014, 10'h2CC, 2'b11, 2'b00, 2'b00, 0, 2'b01));
    // underflow on channel 1
    tbl.push_back(mk(0, 10'h000, 2'b10, 10'h014, 10'h2CC, 2'b11, 2'b00, 2'b00, 1, 2'b11));
    tbl.push_back(mk(0, 10'h000, 2'b00, 10'h014, 10'h2CC, 2'b11, 2'b00, 2'b00, 0, 2'b11));
    // full channel 1 with simultaneous push and pop
    tbl.push_back(mk(1, 10'h201, 2'b00, 10'h014, 10'h2CC, 2'b01, 2'b00, 2'b00, 0, 2'b11));
    tbl.push_back(mk(1, 10'h202, 2'b00, 10'h014, 10'h2CC, 2'b01, 2'b00, 2'b00, 0, 2'b11));
    tbl.push_back(mk(1, 10'h203, 2'b00, 10'h014, 10'h2CC, 2'b01, 2'b00, 2'b10, 0, 2'b11));
    tbl.push_back(mk(1, 10'h204, 2'b00, 10'h014, 10'h2CC, 2'b01, 2'b10, 2'b10, 0, 2'b11));
    tbl.push_back(mk(1, 10'h299, 2'b10, 10'h014, 10'h201, 2'b01, 2'b10, 2'b10, 0, 2'b11));
    tbl.push_back(mk(0, 10'h000, 2'b10, 10'h014, 10'h202, 2'b01, 2'b00, 2'b10, 0, 2'b11));
    tbl.push_back(mk(0, 10'h000, 2'b10, 10'h014, 10'h203, 2'b01, 2'b00, 2'b00, 0, 2'b11));
    tbl.push_back(mk(0, 10'h000, 2'b10, 10'h014, 10'h204, 2'b01, 2'b00, 2'b00, 0, 2'b11));
    tbl.push_back(mk(0, 10'h000, 2'b10, 10'h014, 10'h299, 2'b11, 2'b00, 2'b00, 0, 2'b11));
    // push and pop on an empty channel: pop underflows, push lands
    tbl.push_back(mk(1, 10'h0AA, 2'b01, 10'h014, 10'h299, 2'b10, 2'b00, 2'b00, 1, 2'b11));
    tbl.push_back(mk(0, 10'h000, 2'b01, 10'h0AA, 10'h299, 2'b11, 2'b00, 2'b00, 0, 2'b11));

    // reset held for 3 cycles
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_empty", 32'(fifo_empty), 32'h3);
    check("rst_full", 32'(fifo_full), 32'h0);
    check("rst_af", 32'(almost_full), 32'h0);
    check("rst_error", 32'(Error), 32'h0);
    check("rst_err_status", 32'(err_status), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].p);
      check($sformatf("v%0d_out0", i), 32'(out[9:0]), 32'(tbl[i].o0));
      check($sformatf("v%0d_out1", i), 32'(out[19:10]), 32'(tbl[i].o1));
      check($sformatf("v%0d_empty", i), 32'(fifo_empty), 32'(tbl[i].em));
      check($sformatf("v%0d_full", i), 32'(fifo_full), 32'(tbl[i].fu));
      check($sformatf("v%0d_af", i), 32'(almost_full), 32'(tbl[i].af));
      check($sformatf("v%0d_error", i), 32'(Error), 32'(tbl[i].er));
      check($sformatf("v%0d_err_status", i), 32'(err_status), 32'(tbl[i].es));
    end

    // mid-run asynchronous reset with two words in each channel
    step(1, 10'h0A1, 2'b00);
    step(1, 10'h2B1, 2'b00);
    step(1, 10'h0A2, 2'b00);
    step(1, 10'h2B2, 2'b00);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 32'h0);
    check("mid_rst_empty", 32'(fifo_empty), 32'h3);
    check("mid_rst_full", 32'(fifo_full), 32'h0);
    check("mid_rst_error", 32'(Error), 32'h0);
    check("mid_rst_err_status", 32'(err_status), 32'h0);
    mq0.delete(); mq1.delete();
    m_o0 = '0; m_o1 = '0; m_es = '0;
    @(posedge clk);
    #1;
    check("mid_rst_hold_empty", 32'(fifo_empty), 32'h3);
    check("mid_rst_hold_out", 32'(out), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 10'h000, 2'b01);
    check("post_rst_underflow_err", 32'(Error), 32'h1);
    check("post_rst_underflow_es", 32'(err_status), 32'h1);
    check("post_rst_underflow_out", 32'(out), 32'h0);
    step(0, 10'h000, 2'b00);
    check("post_rst_error_clear", 32'(Error), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
